fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single 32-bit write port of the asynchronous FIFO between several producers in the write clock domain. Each producer has a valid/ready handshake with an optional end-of-packet marker. The arbiter grants one producer at a time and holds the grant for a bounded burst. It drives the FIFO's `w_en`/`wdata` and honours its `full` flag, so no word is lost or duplicated.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 32: data width; matches the FIFO data width.
- `MAX_BURST`, 4: maximum words per grant, 1..16.

- `wclk` in 1: write-domain clock; the only clock of this block.
- `wrst` in 1: asynchronous, active-low reset. Asserting it immediately clears all state; de-assertion is synchronous to `wclk` upstream.
- `req_valid` in NREQ: per-requester data valid.
- `req_data` in NREQ*DW: packed data; requester i occupies bits [i*DW +: DW].
- `req_last` in NREQ: marks the final word of a packet; qualified by `req_valid`.
- `req_ready` out NREQ: transfer accepted this cycle; at most one bit high.
- `full` in 1: FIFO full flag, write domain.
- `w_en` out 1: FIFO write enable.
- `wdata` out DW: FIFO write data.
- `grant` out NREQ: registered one-hot owner, or all-zero.
- `busy` out 1: high when the FSM is in BURST.

## Operation
- FSM states:
  - IDLE: no owner; `grant`=0.
  - BURST: `grant` is one-hot; `gidx` is the owner index.
- Registers:
  - `state`.
  - `grant`.
  - `last_idx`: index of the last owner, width clog2(NREQ).
  - `burst_cnt`: width clog2(MAX_BURST)+1.
- Round-robin pick: the first i with `req_valid[i]`=1, scanning from `last_idx`+1 modulo NREQ. The previous owner has the lowest priority.
- Transfer condition: `xfer` = BURST & `req_valid[gidx]` & ~`full`.
  - `w_en` = `xfer`.
  - `req_ready[gidx]` = `xfer`.
  - `wdata` = `req_data[gidx]` while in BURST, otherwise 0.
- All of `w_en`, `req_ready` and `wdata` are combinational from registered grant and the current inputs. There is no extra register stage.
- Release of the grant in BURST happens when any of these is true:
  - (a) `xfer` & `req_last[gidx]`.
  - (b) `xfer` & (`burst_cnt`==MAX_BURST-1).
  - (c) ~`req_valid[gidx]` (owner withdrew). No transfer occurs that cycle.
- On release:
  - `last_idx` ← `gidx`.
  - The next pick is evaluated in the same cycle from current `req_valid`, with the released owner at lowest priority.
  - If any requester is valid: stay in BURST with the new grant and `burst_cnt` ← 0.
  - Otherwise go to IDLE.
- IDLE: if any requester is valid, grant the pick, set `burst_cnt` ← 0 and enter BURST.
- `burst_cnt` increments on each `xfer` that does not release the grant.
- `full` high: the grant is held indefinitely. `burst_cnt` is frozen and there is no timeout. A `full` cycle never triggers release by itself.
- An owner whose `req_valid` drops while `full`=1 still releases under rule (c).
- Reset values:
  - `state`=IDLE, `grant`=0, `last_idx`=NREQ-1 (requester 0 wins first), `burst_cnt`=0.
  - `w_en`=0, `req_ready`=0, `busy`=0, `wdata`=0.
- Reset mid-burst: the grant is lost immediately. A partially sent packet is the producer's responsibility; the arbiter does not resume it.

## Timing
- Arbitration latency: a request arriving in IDLE is granted on the next `wclk` edge. The first `w_en` occurs in that next cycle if `full`=0.
- Throughput: 1 word/cycle within a burst. Handover between owners costs zero cycles when another requester is valid at release.
- A single owner that is still valid after a MAX_BURST release is re-granted only if it is the sole valid requester. In that case there is no bubble.
- `req_ready`/`w_en` respond combinationally to `full` within the same cycle. `full` must be the registered flag from the write-pointer logic.

## Structure
- Package `fifo_arb_pkg`:
  - FSM state encoding (IDLE=0, BURST=1).
  - Default constants for NREQ, DW and MAX_BURST.
  - clog2 helper.
- Sub-module `rr_picker`: combinational rotate-priority encoder.
  - Inputs: `req` [NREQ], `last_idx`.
  - Outputs: `any`, `idx`.
  - Instantiated once. The same instance serves both the IDLE pick and the release pick.

## Test plan
- Reset behaviour: with `wrst`=0, all requesters valid → `grant`=0, `w_en`=0, `req_ready`=0. Release reset → requester 0 is granted at the next edge and `w_en`=1 the cycle after reset release + 1.
- Burst cap: MAX_BURST=4, requesters 0 and 1 continuously valid, `req_last`=0, `full`=0 → sequence of 4 words from 0, then 4 from 1, then 4 from 0, with no idle cycle between bursts.
- Packet lock: requester 2 sends 2 words with `req_last` on the second while requester 3 is valid → exactly 2 words from 2, then grant 3 in the next cycle.
- Full stall: owner 1 after 2 words, `full` held for 5 cycles → `w_en`=0 and `req_ready`=0 for those 5 cycles, grant unchanged, `burst_cnt` stays 2. After `full` clears, exactly 2 more words before release.
- Withdraw: owner 0 drops `req_valid` mid-burst while requester 2 is valid → no write that cycle, grant moves to 2 on the next edge.
- Reset mid-burst: assert `wrst` during the third word of owner 1 → outputs go to 0 immediately. After release, requester 0 has priority (`last_idx`=NREQ-1).

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 32;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder: first set request after last_idx, wrapping around.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_idx,
  output logic            any,
  output logic [IW-1:0]   idx
);

  int j_s;

  // Scan from farthest to nearest so the closest hit after last_idx wins.
  always_comb begin
    idx = '0;
    j_s = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j_s = (int'(last_idx) + k) % NREQ;
      idx = req[j_s] ? IW'(j_s) : idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// with packet lock, bounded bursts and back-pressure from the FIFO full flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  input  logic               full,
  output logic               w_en,
  output logic [DW-1:0]      wdata,
  output logic [NREQ-1:0]    grant,
  output logic               busy
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  arb_state_e       state_q;
  logic [NREQ-1:0]  grant_q;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    last_idx_q;
  logic [CW-1:0]    burst_cnt_q;

  logic             in_burst_s;
  logic             owner_valid_s;
  logic             owner_last_s;
  logic             xfer_s;
  logic             release_s;
  logic [IW-1:0]    pick_base_s;
  logic             pick_any_s;
  logic [IW-1:0]    pick_idx_s;
  logic [NREQ-1:0]  pick_grant_d;

  assign in_burst_s    = (state_q == ST_BURST);
  assign owner_valid_s = req_valid[gidx_q];
  assign owner_last_s  = req_last[gidx_q];
  assign xfer_s        = in_burst_s & owner_valid_s & ~full;
  // A full cycle alone never releases; only withdrawal, packet end or burst cap do.
  assign release_s     = in_burst_s &
                         (~owner_valid_s |
                          (xfer_s & (owner_last_s | (burst_cnt_q == CNT_LAST))));

  // During a burst the current owner is the rotation base, so a release
  // in this cycle already sees it at lowest priority.
  assign pick_base_s  = in_burst_s ? gidx_q : last_idx_q;
  assign pick_grant_d = ONE_HOT0 << pick_idx_s;

  rr_picker #(
    .NREQ(NREQ)
  ) u_picker (
    .req      (req_valid),
    .last_idx (pick_base_s),
    .any      (pick_any_s),
    .idx      (pick_idx_s)
  );

  assign w_en      = xfer_s;
  assign req_ready = xfer_s ? grant_q : '0;
  assign wdata     = in_burst_s ? req_data[gidx_q*DW +: DW] : '0;
  assign grant     = grant_q;
  assign busy      = in_burst_s;

  // Grant FSM: IDLE picks an owner; BURST transfers, counts and hands over.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_idx_q  <= IDX_LAST;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any_s) begin
            state_q     <= ST_BURST;
            grant_q     <= pick_grant_d;
            gidx_q      <= pick_idx_s;
            burst_cnt_q <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (release_s) begin
            last_idx_q  <= gidx_q;
            burst_cnt_q <= '0;
            if (pick_any_s) begin
              grant_q <= pick_grant_d;
              gidx_q  <= pick_idx_s;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= '0;
            end
          end else if (xfer_s) begin
            burst_cnt_q <= burst_cnt_q + CW'(1);
          end else begin
            burst_cnt_q <= burst_cnt_q;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          grant_q     <= '0;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus random traffic.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 32;
  localparam int MAX_BURST = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  typedef struct {
    int            src;
    logic [DW-1:0] d;
  } exp_t;

  logic               wclk;
  logic               wrst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               full;
  logic               w_en;
  logic [DW-1:0]      wdata;
  logic [NREQ-1:0]    grant;
  logic               busy;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)
  ) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .full(full), .w_en(w_en),
    .wdata(wdata), .grant(grant), .busy(busy)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  word_t           pq [NREQ][$];
  exp_t            exp_word_q [$];
  logic [NREQ-1:0] exp_grant_q [$];

  // Reference model: owner (-1 = none), words sent in current burst, previous owner.
  int m_owner;
  int m_sent;
  int m_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int base);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(base + k) % NREQ]) return (base + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_sent  = 0;
    m_last  = NREQ - 1;
    exp_word_q.delete();
    exp_grant_q.delete();
    for (int i = 0; i < NREQ; i++) pq[i].delete();
  endtask

  task automatic model(input logic [NREQ-1:0] v, input logic f);
    logic [NREQ-1:0] g;
    exp_t e;
    bit xf;
    bit lw;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    exp_grant_q.push_back(g);
    if (m_owner < 0) begin
      m_owner = pick(v, m_last);
      m_sent  = 0;
    end else begin
      xf = v[m_owner] && !f;
      lw = 1'b0;
      if (xf) begin
        e.src = m_owner;
        e.d   = pq[m_owner][0].d;
        lw    = pq[m_owner][0].l;
        exp_word_q.push_back(e);
        void'(pq[m_owner].pop_front());
        m_sent++;
      end
      if (!v[m_owner] || (xf && (lw || m_sent == MAX_BURST))) begin
        m_last  = m_owner;
        m_owner = pick(v, m_owner);
        m_sent  = 0;
      end
    end
  endtask

  task automatic step(input logic [NREQ-1:0] want, input logic f);
    logic [NREQ-1:0] v;
    @(negedge wclk);
    for (int i = 0; i < NREQ; i++) begin
      v[i] = want[i] && (pq[i].size() > 0);
      if (v[i]) begin
        req_data[i*DW +: DW] = pq[i][0].d;
        req_last[i]          = pq[i][0].l;
      end else begin
        req_data[i*DW +: DW] = $urandom;
        req_last[i]          = 1'($urandom);
      end
    end
    req_valid = v;
    full      = f;
    #1;
    model(v, f);
  endtask

  task automatic add_words(input int src, input int n, input bit last_at_end);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.d = {8'(src), 8'(k), 16'($urandom)};
      w.l = last_at_end && (k == n - 1);
      pq[src].push_back(w);
    end
  endtask

  task automatic do_reset();
    @(posedge wclk);
    #2;
    mon_en    = 1'b0;
    wrst      = 1'b0;
    req_valid = '0;
    full      = 1'b0;
    model_reset();
    @(posedge wclk);
    #1;
    wrst   = 1'b1;
    mon_en = 1'b1;
  endtask

  logic [NREQ-1:0] mon_eg;
  exp_t            mon_ew;
  logic            mon_ex;

  // Monitor: compares DUT outputs against whatever the model queued this cycle.
  always begin
    @(negedge wclk);
    #3;
    if (mon_en && exp_grant_q.size() > 0) begin
      mon_eg = exp_grant_q.pop_front();
      chk("grant", 64'(grant), 64'(mon_eg));
      chk("busy", 64'(busy), 64'(mon_eg != '0));
      mon_ex = (exp_word_q.size() > 0);
      chk("w_en", 64'(w_en), 64'(mon_ex));
      if (mon_ex) begin
        mon_ew = exp_word_q.pop_front();
        if (w_en) begin
          chk("wdata", 64'(wdata), 64'(mon_ew.d));
          chk("req_ready", 64'(req_ready), 64'(1) << mon_ew.src);
        end
      end else begin
        chk("req_ready_idle", 64'(req_ready), 64'(0));
      end
    end
  end

  initial begin
    wrst      = 1'b0;
    req_valid = '1;
    req_data  = '1;
    req_last  = '0;
    full      = 1'b0;
    model_reset();
    repeat (2) @(negedge wclk);
    #3;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_w_en", 64'(w_en), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // Reset release with everyone valid, then burst cap rotation 0/1.
    @(posedge wclk);
    #1;
    wrst      = 1'b1;
    req_valid = '0;
    mon_en    = 1'b1;
    for (int i = 0; i < NREQ; i++) add_words(i, 2, 1'b0);
    add_words(0, 12, 1'b0);
    add_words(1, 12, 1'b0);
    for (int c = 0; c < 4; c++) step(4'b1111, 1'b0);
    for (int c = 0; c < 26; c++) step(4'b0011, 1'b0);

    // Packet lock: 2-word packet from 2 while 3 waits.
    do_reset();
    add_words(2, 2, 1'b1);
    add_words(3, 4, 1'b0);
    for (int c = 0; c < 8; c++) step(4'b1100, 1'b0);

    // Full stall on owner 1 after 2 words.
    do_reset();
    add_words(1, 8, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0010, 1'b0);
    for (int c = 0; c < 5; c++) step(4'b0010, 1'b1);
    for (int c = 0; c < 6; c++) step(4'b0010, 1'b0);

    // Owner 0 withdraws mid-burst while 2 is waiting.
    do_reset();
    add_words(0, 6, 1'b0);
    add_words(2, 3, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b0101, 1'b0);
    step(4'b0100, 1'b0);
    for (int c = 0; c < 6; c++) step(4'b0101, 1'b0);

    // Reset during the third word of owner 1.
    do_reset();
    add_words(1, 6, 1'b0);
    for (int c = 0; c < 4; c++) step(4'b0010, 1'b0);
    #1;
    mon_en = 1'b0;
    wrst   = 1'b0;
    #1;
    chk("midrst_w_en", 64'(w_en), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    chk("midrst_grant", 64'(grant), 64'(0));
    chk("midrst_wdata", 64'(wdata), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    req_valid = '0;
    model_reset();
    @(posedge wclk);
    #1;
    wrst   = 1'b1;
    mon_en = 1'b1;
    add_words(0, 3, 1'b1);
    add_words(1, 3, 1'b1);
    for (int c = 0; c < 9; c++) step(4'b0011, 1'b0);

    // Random traffic with random packets, withdrawals and back-pressure.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [NREQ-1:0] want;
      for (int i = 0; i < NREQ; i++) begin
        if (pq[i].size() == 0) add_words(i, $urandom_range(1, 6), 1'b1);
        want[i] = ($urandom_range(0, 3) != 0);
      end
      step(want, ($urandom_range(0, 4) == 0));
    end

    @(negedge wclk);
    #4;
    mon_en = 1'b0;
    chk("drain", 64'(exp_word_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
